// File: rtl/cdc_pkg.sv
// Shared types and constants for the toggle-handshake CDC sender.
package cdc_pkg;

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_ACK = 1'b1
    } xfer_state_e;

    localparam int CDC_SYNC_STAGES = 3;
    localparam int XFER_COUNT_W    = 16;

endpackage

// File: rtl/synchronizer.sv
// Multi-flop synchronizer; async reset loads RESET_STATE into every stage.
module synchronizer #(
    parameter int                 WIDTH       = 1,
    parameter int                 STAGES      = 2,
    parameter logic [WIDTH-1:0]   RESET_STATE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [STAGES-1:0][WIDTH-1:0] chain_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            chain_q <= {STAGES{RESET_STATE}};
        end else begin
            chain_q <= {chain_q[STAGES-2:0], d};
        end
    end

    assign q = chain_q[STAGES-1];

endmodule

// File: rtl/cdc_handshake_sender.sv
// Source side of a toggle req/ack multi-bit CDC: holds one word until the resynchronized ack matches req.
// Optional acknowledge watchdog enabled by the macro CDC_HANDSHAKE_TIMEOUT_EN.
module cdc_handshake_sender
    import cdc_pkg::*;
#(
    parameter int WIDTH          = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [WIDTH-1:0]        in_data,
    output logic [WIDTH-1:0]        xfer_data_o,
    output logic                    xfer_req_o,
    input  logic                    xfer_ack_i,
    output logic                    busy,
    output logic [XFER_COUNT_W-1:0] xfer_count,
    output logic                    timeout_err
);

    xfer_state_e state;
    xfer_state_e next_state;
    logic        ack_s;
    logic        accept;
    logic        complete;

    synchronizer #(
        .WIDTH       (1),
        .STAGES      (CDC_SYNC_STAGES),
        .RESET_STATE (1'b0)
    ) u_ack_sync (
        .clk   (clk),
        .reset (reset),
        .d     (xfer_ack_i),
        .q     (ack_s)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Gating in_ready on ack_s == req keeps a stale ack after a local reset from being taken as completion.
    always_comb begin
        next_state = state;
        in_ready   = 1'b0;
        busy       = 1'b0;
        accept     = 1'b0;
        complete   = 1'b0;
        case (state)
            IDLE: begin
                in_ready = (ack_s == xfer_req_o);
                accept   = in_valid && in_ready;
                if (accept) begin
                    next_state = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                busy = 1'b1;
                if (ack_s == xfer_req_o) begin
                    complete   = 1'b1;
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            xfer_data_o <= '0;
            xfer_req_o  <= 1'b0;
            xfer_count  <= '0;
        end else begin
            if (accept) begin
                xfer_data_o <= in_data;
                xfer_req_o  <= ~xfer_req_o;
            end
            if (complete) begin
                xfer_count <= xfer_count + XFER_COUNT_W'(1);
            end
        end
    end

`ifdef CDC_HANDSHAKE_TIMEOUT_EN
    localparam int TIMEOUT_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [TIMEOUT_W-1:0] timeout_cnt;

    // Watchdog only flags; the FSM keeps waiting so a late ack still completes the word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timeout_cnt <= '0;
            timeout_err <= 1'b0;
        end else begin
            if (accept) begin
                timeout_cnt <= '0;
            end else if ((state == WAIT_ACK) && (timeout_cnt != TIMEOUT_W'(TIMEOUT_CYCLES))) begin
                timeout_cnt <= timeout_cnt + TIMEOUT_W'(1);
            end
            if ((state == WAIT_ACK) && (timeout_cnt == TIMEOUT_W'(TIMEOUT_CYCLES - 1))) begin
                timeout_err <= 1'b1;
            end
        end
    end
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = (TIMEOUT_CYCLES > 0);
    assign timeout_err        = 1'b0;
`endif

endmodule
